mbist_addr_gen: RTL and testbench

//  Parametrised MBIST address sequencer; successor to the plain up/down address counter.

---
 rtl/mbist_pkg.sv | 13 +
 rtl/mbist_addr_step.sv | 50 +++++
 rtl/mbist_addr_gen.sv | 131 +++++++++++++
 tb/tb_mbist_addr_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and default geometry for the MBIST address sequencer.
package mbist_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int COL_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mbist_addr_step.sv
// Combinational step: from the current address and latched sweep configuration,
// produce the next address in sweep order and flag whether addr is the final one.
module mbist_addr_step
  import mbist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              up,
  input  logic              col_major,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              is_final
);

  localparam int ROW_W = ADDR_W - COL_W;

  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_step;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_step;
  logic              row_wrap;
  logic [ADDR_W-1:0] final_addr;

  always_comb begin
    row      = addr[ADDR_W-1:COL_W];
    col      = addr[COL_W-1:0];
    row_step = up ? row + 1'b1 : row - 1'b1;
    col_step = up ? col + 1'b1 : col - 1'b1;
    row_wrap = up ? (&row) : ~(|row);

    if (col_major) begin
      // Row is the fast field; on its wrap the column moves and the row restarts.
      if (row_wrap) begin
        next_addr = {(up ? {ROW_W{1'b0}} : {ROW_W{1'b1}}), col_step};
      end else begin
        next_addr = {row_step, col};
      end
      final_addr = up ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    end else begin
      next_addr  = up ? addr + 1'b1 : addr - 1'b1;
      final_addr = up ? hi_addr : lo_addr;
    end

    is_final = (addr == final_addr);
  end

endmodule

// File: rtl/mbist_addr_gen.sv
// MBIST address sequencer: sweeps a bounded window (row-major) or the full space
// (column-major), up or down, under start/advance/abort from the March controller.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              up,
  input  logic              col_major,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  input  logic              advance,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              last,
  output logic              done,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              err_reg, err_next;
  logic              up_reg, up_next;
  logic              cm_reg, cm_next;
  logic [ADDR_W-1:0] lo_reg, lo_next;
  logic [ADDR_W-1:0] hi_reg, hi_next;

  logic [ADDR_W-1:0] step_addr;
  logic              step_final;
  logic [ADDR_W-1:0] first_addr;

  mbist_addr_step #(
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) u_step (
    .addr      (addr_reg),
    .up        (up_reg),
    .col_major (cm_reg),
    .lo_addr   (lo_reg),
    .hi_addr   (hi_reg),
    .next_addr (step_addr),
    .is_final  (step_final)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
      up_reg    <= 1'b0;
      cm_reg    <= 1'b0;
      lo_reg    <= '0;
      hi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
      up_reg    <= up_next;
      cm_reg    <= cm_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
    end
  end

  // First address comes from the live inputs because it is loaded on the start edge.
  always_comb begin
    if (col_major) begin
      first_addr = up ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
    end else begin
      first_addr = up ? lo_addr : hi_addr;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    err_next   = err_reg;
    up_next    = up_reg;
    cm_next    = cm_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          up_next = up;
          cm_next = col_major;
          lo_next = lo_addr;
          hi_next = hi_addr;
          if (lo_addr > hi_addr) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b0;
            addr_next  = first_addr;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (advance) begin
          if (step_final) begin
            state_next = ST_DONE;
          end else begin
            addr_next = step_addr;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign addr = addr_reg;
  assign busy = (state_reg == ST_RUN);
  assign last = (state_reg == ST_RUN) && step_final;
  assign done = (state_reg == ST_DONE);
  assign err  = err_reg;

endmodule

// File: tb/tb_mbist_addr_gen.sv
// Randomised self-checking bench for mbist_addr_gen against a sequence-list reference.
module tb_mbist_addr_gen;

  localparam int AW = 4;
  localparam int CW = 2;
  localparam int RW = AW - CW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          up;
  logic          col_major;
  logic [AW-1:0] lo_addr;
  logic [AW-1:0] hi_addr;
  logic          advance;
  logic          abort;
  logic [AW-1:0] addr;
  logic          busy;
  logic          last;
  logic          done;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  mbist_addr_gen #(.ADDR_W(AW), .COL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .up        (up),
    .col_major (col_major),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .advance   (advance),
    .abort     (abort),
    .addr      (addr),
    .busy      (busy),
    .last      (last),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full list of addresses a sweep must visit, in order, built from the ordering rules.
  function automatic void build_seq(input bit u, input bit cm, input int lo, input int hi,
                                    output logic [AW-1:0] q[$]);
    q = {};
    if (cm) begin
      if (u) begin
        for (int c = 0; c < (1 << CW); c++)
          for (int r = 0; r < (1 << RW); r++)
            q.push_back(AW'(r * (1 << CW) + c));
      end else begin
        for (int c = (1 << CW) - 1; c >= 0; c--)
          for (int r = (1 << RW) - 1; r >= 0; r--)
            q.push_back(AW'(r * (1 << CW) + c));
      end
    end else if (u) begin
      for (int a = lo; a <= hi; a++) q.push_back(AW'(a));
    end else begin
      for (int a = hi; a >= lo; a--) q.push_back(AW'(a));
    end
  endfunction

  task automatic do_sweep(input string name, input bit u, input bit cm,
                          input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                          input int gap_pct, input bit scramble);
    logic [AW-1:0] q[$];
    int idx;
    int cycles;
    bit adv;
    build_seq(u, cm, int'(lo), int'(hi), q);
    start = 1'b1; up = u; col_major = cm; lo_addr = lo; hi_addr = hi;
    advance = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < q.size() && cycles < 400) begin
      n_tests++;
      if (busy !== 1'b1 || addr !== q[idx] || last !== (idx == q.size() - 1) ||
          done !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s step %0d: addr=%0d busy=%b last=%b done=%b err=%b, required addr=%0d busy=1 last=%b done=0 err=0",
                 name, idx, addr, busy, last, done, err, q[idx], (idx == q.size() - 1));
      end
      adv = ($urandom_range(99) >= gap_pct);
      advance = adv;
      if (scramble) begin
        start = 1'(($urandom));
        up = 1'(($urandom));
        col_major = 1'(($urandom));
        lo_addr = AW'($urandom);
        hi_addr = AW'($urandom);
      end
      @(negedge clk);
      if (adv) idx++;
      cycles++;
    end
    if (cycles >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: reached step %0d of %0d", name, idx, q.size());
    end
    advance = 1'b0;
    start = 1'b1; up = 1'b1; col_major = 1'b0; lo_addr = '0; hi_addr = '1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || last !== 1'b0 || addr !== q[q.size() - 1]) begin
      n_fail++;
      $display("FAIL %s end: done=%b busy=%b last=%b addr=%0d, required done=1 busy=0 last=0 addr=%0d",
               name, done, busy, last, addr, q[q.size() - 1]);
    end
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || addr !== q[q.size() - 1]) begin
      n_fail++;
      $display("FAIL %s after_done (start in DONE ignored): done=%b busy=%b addr=%0d, required 0 0 %0d",
               name, done, busy, addr, q[q.size() - 1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; up = 1'b1; col_major = 1'b0;
    lo_addr = 4'd3; hi_addr = 4'd6; advance = 1'b1; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (addr !== '0 || busy !== 1'b0 || last !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: addr=%0d busy=%b last=%b done=%b err=%b, required all 0",
               addr, busy, last, done, err);
    end
    rst = 1'b0; start = 1'b0; advance = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_config();
    start = 1'b1; up = 1'b1; col_major = 1'b0; lo_addr = 4'd9; hi_addr = 4'd2;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || addr !== 4'd0) begin
      n_fail++;
      $display("FAIL bad_config: err=%b done=%b busy=%b addr=%0d, required 1 1 0 0",
               err, done, busy, addr);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_config_sticky: err=%b done=%b busy=%b, required 1 0 0", err, done, busy);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; up = 1'b1; col_major = 1'b0; lo_addr = 4'd0; hi_addr = 4'd15;
    @(negedge clk);
    start = 1'b0;
    advance = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (addr !== 4'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: addr=%0d busy=%b, required 5 1", addr, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || last !== 1'b0 || addr !== 4'd5) begin
        n_fail++;
        $display("FAIL abort cycle %0d: busy=%b done=%b last=%b addr=%0d, required 0 0 0 5",
                 i, busy, done, last, addr);
      end
      @(negedge clk);
    end
    do_sweep("abort_resume", 1'b1, 1'b0, 4'd2, 4'd7, 0, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    start = 1'b1; up = 1'b0; col_major = 1'b0; lo_addr = 4'd0; hi_addr = 4'd15;
    @(negedge clk);
    start = 1'b0; advance = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; advance = 1'b0;
    n_tests++;
    if (addr !== '0 || busy !== 1'b0 || last !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: addr=%0d busy=%b last=%b done=%b err=%b, required all 0",
               addr, busy, last, done, err);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep_idle: busy=%b, required 0", busy);
    end
    start = 1'b1; up = 1'b1; lo_addr = 4'd4; hi_addr = 4'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (addr !== 4'd4 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL advance_gap cycle %0d: addr=%0d busy=%b, required 4 1", i, addr, busy);
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom);
      b = AW'($urandom);
      if (a > b) begin
        logic [AW-1:0] t;
        t = a; a = b; b = t;
      end
      do_sweep($sformatf("random%0d", i), 1'($urandom), 1'($urandom), a, b, 30, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; up = 1'b0; col_major = 1'b0;
    lo_addr = '0; hi_addr = '0; advance = 1'b0; abort = 1'b0;
    test_reset();
    test_bad_config();
    do_sweep("row_up_3_6", 1'b1, 1'b0, 4'd3, 4'd6, 0, 1'b0);
    do_sweep("row_down_0_15", 1'b0, 1'b0, 4'd0, 4'd15, 0, 1'b0);
    do_sweep("col_up", 1'b1, 1'b1, 4'd0, 4'd15, 0, 1'b0);
    do_sweep("col_down", 1'b0, 1'b1, 4'd5, 4'd9, 20, 1'b0);
    do_sweep("single_addr", 1'b1, 1'b0, 4'd7, 4'd7, 0, 1'b0);
    test_abort();
    test_reset_mid_sweep();
    do_sweep("row_gaps", 1'b1, 1'b0, 4'd1, 4'd12, 60, 1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
